// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcode encodings, controller
// state type and opcode classification helpers. Nothing here depends on WIDTH.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // True for opcodes served by the iterative multiply/divide engine.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // True for the divide family (restoring divide instead of shift-add).
    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // True for opcodes whose answer lives in the upper/remainder register.
    function automatic logic takes_hi(input logic [3:0] op);
        return (op == OP_MULHU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / divide engine, one bit per clock.
// A start pulse loads the operands; exactly WIDTH iteration cycles follow.
// done is high during the final iteration cycle and result then carries the
// value that iteration produces, so the caller can register it on that edge.
// Multiply: {hi,lo} is the shift-add product register, lo starts as src_a.
// Divide:   hi is the partial remainder, lo shifts dividend bits out and
//           quotient bits in. A zero divisor naturally yields quotient all
//           ones and remainder equal to the dividend.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // One iteration step for either algorithm, selected by the captured opcode.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        shifted = {hi_q, lo_q[WIDTH-1]};
        trial   = shifted - {1'b0, b_q};
        if (is_div(op_q)) begin
            if (!trial[WIDTH]) begin
                hi_nxt = trial[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Operand capture on start, then a down-counted run of WIDTH iterations.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            op_q <= OP_ADD;
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (start) begin
            cnt  <= CNT_W'(WIDTH);
            op_q <= op;
            hi_q <= '0;
            lo_q <= op_a;
            b_q  <= op_b;
        end else if (cnt != '0) begin
            cnt  <= cnt - CNT_W'(1);
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
        end
    end

    assign done   = (cnt == CNT_W'(1));
    assign result = takes_hi(op_q) ? hi_nxt : lo_nxt;

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops are evaluated from the inputs on the accepting edge and
// presented one cycle later. MUL/MULHU/DIVU/REMU use alu_muldiv_iter, which
// is only built when the macro ALU_MULDIV_EN is defined; otherwise those
// opcodes complete in one cycle with result 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request; in_ready high
// CALC    | iterative engine running (WIDTH cycles); busy high
// DONE    | result/zero held with out_valid high until out_ready
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    alu_state_t       state;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] single_res;

    assign shamt = src_b[SH_W-1:0];

`ifdef ALU_MULDIV_EN
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    assign md_start = (state == ST_IDLE) && in_valid && is_muldiv(alu_control);

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (alu_control),
        .op_a   (src_a),
        .op_b   (src_b),
        .done   (md_done),
        .result (md_result)
    );
`endif

    // Single-cycle datapath, evaluated from the live request inputs.
    always_comb begin
        single_res = '0;
        case (alu_control)
            OP_ADD:  single_res = src_a + src_b;
            OP_SUB:  single_res = src_a - src_b;
            OP_AND:  single_res = src_a & src_b;
            OP_OR:   single_res = src_a | src_b;
            OP_XOR:  single_res = src_a ^ src_b;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_SLL:  single_res = src_a << shamt;
            OP_SRL:  single_res = src_a >> shamt;
            OP_SRA:  single_res = WIDTH'($signed(src_a) >>> shamt);
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: single_res = '0;
            default: single_res = '0;
        endcase
    end

    // Controller: state sequencing with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifdef ALU_MULDIV_EN
                        if (is_muldiv(alu_control)) begin
                            state <= ST_CALC;
                            busy  <= 1'b1;
                        end else
`endif
                        begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= single_res;
                            zero      <= (single_res == '0);
                        end
                    end
                end
                ST_CALC: begin
`ifdef ALU_MULDIV_EN
                    if (md_done) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= md_result;
                        zero      <= (md_result == '0);
                    end
`else
                    // Unreachable without the engine; fall back to IDLE.
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
`endif
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH = 32). Expected results come
// from a behavioural model and sit in a scoreboard queue until the DUT
// presents them. Expectations follow ALU_MULDIV_EN when it is defined.
`timescale 1ns/1ps
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int WIDTH = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          busy_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_iter(input logic [3:0] op);
        return MD_EN && (op >= 4'd10) && (op <= 4'd13);
    endfunction

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        logic [4:0]  sh;
        p  = {32'd0, a} * {32'd0, b};
        sh = b[4:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return {31'd0, ($signed(a) < $signed(b))};
            4'd6:  return {31'd0, (a < b)};
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return $signed(a) >>> sh;
            4'd10: return MD_EN ? p[31:0] : 32'd0;
            4'd11: return MD_EN ? p[63:32] : 32'd0;
            4'd12: return !MD_EN ? 32'd0 : ((b == 0) ? 32'hFFFF_FFFF : a / b);
            4'd13: return !MD_EN ? 32'd0 : ((b == 0) ? a : a % b);
            default: return 32'd0;
        endcase
    endfunction

    // Issue one request (called at a negedge); returns #1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit track);
        exp_t e;
        int   w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", (w < 200), 1);
        alu_control = op;
        src_a       = a;
        src_b       = b;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        alu_control = 4'($urandom);
        src_a       = $urandom;
        src_b       = $urandom;
        if (track) begin
            e.res      = model(op, a, b);
            e.lat      = is_iter(op) ? WIDTH + 1 : 1;
            e.busy_cyc = is_iter(op) ? WIDTH : 0;
            sb_q.push_back(e);
        end
    endtask

    // Wait for the next result, compare against the scoreboard, optionally stall.
    task automatic receive(input int hold);
        exp_t e;
        int   n;
        int   bc;
        bit   seen;
        n    = 1;
        bc   = 0;
        seen = 1'b0;
        while (n <= 200) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (busy) bc++;
            @(posedge clk);
            n++;
        end
        chk("out_valid_seen", seen, 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("latency", n, e.lat);
            chk("busy_cycles", bc, e.busy_cyc);
            chk("busy_in_done", busy, 0);
            chk("result", result, e.res);
            chk("zero", zero, (e.res == 32'd0));
            chk("in_ready_in_done", in_ready, 0);
            for (int k = 0; k < hold; k++) begin
                in_valid    = 1'b1;
                alu_control = OP_ADD;
                src_a       = $urandom;
                src_b       = $urandom;
                @(posedge clk);
                @(negedge clk);
                chk("stall_result", result, e.res);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cnt;

        rst         = 1'b1;
        in_valid    = 1'b0;
        alu_control = 4'd0;
        src_a       = '0;
        src_b       = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        rst = 1'b0;

        // Directed corner cases
        send(OP_ADD,   32'hFFFF_FFFF, 32'd1, 1);          receive(0);
        send(OP_SLT,   32'hFFFF_FFFF, 32'd1, 1);          receive(0);
        send(OP_SLTU,  32'hFFFF_FFFF, 32'd1, 1);          receive(0);
        send(OP_SRA,   32'h8000_0000, 32'd4, 1);          receive(0);
        send(OP_SRL,   32'h8000_0000, 32'h0000_0104, 1);  receive(0);
        send(OP_SLL,   32'h0000_0001, 32'hFFFF_FFE1, 1);  receive(0);
        send(OP_SUB,   32'd0,         32'd1, 1);          receive(0);
        send(4'b1110,  32'h1234_5678, 32'h1, 1);          receive(0);
        send(4'b1111,  32'hFFFF_FFFF, 32'h1, 1);          receive(0);
        send(OP_MUL,   32'h0001_0000, 32'h0001_0000, 1);  receive(0);
        send(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 1);  receive(0);
        send(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);  receive(0);
        send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);  receive(0);
        send(OP_DIVU,  32'd100,       32'd0, 1);          receive(0);
        send(OP_REMU,  32'd100,       32'd0, 1);          receive(0);
        send(OP_DIVU,  32'd100,       32'd7, 1);          receive(0);
        send(OP_REMU,  32'd100,       32'd7, 1);          receive(0);
        send(OP_DIVU,  32'hFFFF_FFFF, 32'h8000_0001, 1);  receive(0);
        send(OP_REMU,  32'hFFFF_FFFF, 32'h8000_0001, 1);  receive(0);

        // Random mix across every opcode
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (i % 5 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            send(op, a, b, 1);
            receive(0);
        end

        // Consumer back-pressure in DONE with a competing request
        out_ready = 1'b0;
        send(OP_SUB, 32'd5, 32'd7, 1);
        receive(5);
        out_ready = 1'b0;
        send(OP_MUL, 32'd3, 32'd9, 1);
        receive(3);

        // Reset in the middle of a divide; request during reset is ignored
        out_ready = 1'b0;
        send(OP_DIVU, 32'd100, 32'd7, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", busy, MD_EN);
        rst         = 1'b1;
        in_valid    = 1'b1;
        alu_control = OP_ADD;
        src_a       = 32'd1;
        src_b       = 32'd1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_zero", zero, 1);
        chk("abort_busy", busy, 0);
        out_ready = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("abort_no_output", cnt, 0);

        send(OP_ADD, 32'd2, 32'd3, 1);
        receive(0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
